// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//
// Program-counter owner and fetch/branch-resolution sequencer for a
// multi-cycle core. It fetches an instruction, presents it to decode, waits
// for the resolved branch kind, and computes the next PC. Memory-indirect
// targets are read from data memory before the next fetch is issued. A
// saturating counter records taken redirects for performance debug.
//
// Optional feature (compile-time macro):
//   PC_SEQ_ALIGN_CHECK_EN - when defined, a taken target whose low two bits
//   are non-zero loads TRAP_PC instead and pulses misalign for one cycle.
//   When undefined, targets are loaded as-is and misalign is tied low.
//
// Parameters:
//   RESET_PC     PC loaded on reset
//   TRAP_PC      PC loaded on a misaligned taken target (alignment check only)
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   imem_req/addr        instruction fetch request (held until imem_ack)
//   imem_ack/rdata       fetch completion and instruction word
//   instr, instr_valid   latched instruction, valid while awaiting resolution
//   pc, pc4              current PC and PC+4 (mod 2^32)
//   res_valid, res_kind  branch resolution strobe and kind
//   aluout, zero_branch  condition sources (n = aluout[31], z = ~|aluout)
//   reg1, direct, pcimm  register, direct and PC-relative targets
//   mem_addr             pointer for memory-indirect targets
//   dmem_req/addr        target read request (held until dmem_ack)
//   dmem_ack/rdata       target read completion and data
//   taken_cnt            saturating taken-redirect counter
//   misalign             one-cycle pulse on a trapped target
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  input  logic        res_valid,
  input  logic [2:0]  res_kind,
  input  logic [31:0] aluout,
  input  logic        zero_branch,
  input  logic [31:0] reg1,
  input  logic [31:0] direct,
  input  logic [31:0] pcimm,
  input  logic [31:0] mem_addr,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [15:0] taken_cnt,
  output logic        misalign
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2,
    MEMTGT = 2'd3
  } state_t;

  state_t      state_reg;
  state_t      state_next;

  logic        flag_z;
  logic        flag_n;
  logic        advance;   // the current instruction's next PC is decided now
  logic        go_mem;    // target must first be read from data memory
  logic        taken;     // next PC is a redirect rather than pc4
  logic [31:0] target;
  logic [31:0] pc_load;

  assign flag_z = ~|aluout;
  assign flag_n = aluout[31];
  assign pc4    = pc + 32'd4;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (imem_ack)  state_next = DECODE;
      DECODE:  if (res_valid) state_next = go_mem ? MEMTGT : FETCH;
      MEMTGT:  if (dmem_ack)  state_next = FETCH;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic: request and valid strobes are pure state decodes, so an
  // asynchronous reset drops them in the same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    dmem_req    = 1'b0;
    case (state_reg)
      FETCH:   imem_req    = 1'b1;
      DECODE:  instr_valid = 1'b1;
      MEMTGT:  dmem_req    = 1'b1;
      default: ;
    endcase
  end

  assign imem_addr = pc;

  // ---------------------------------------------------------------------------
  // Next-PC selection
  // ---------------------------------------------------------------------------
  always_comb begin
    advance = 1'b0;
    go_mem  = 1'b0;
    taken   = 1'b0;
    target  = pc4;
    case (state_reg)
      DECODE: begin
        if (res_valid) begin
          advance = 1'b1;
          case (res_kind)
            3'b001: if (flag_z)      begin taken = 1'b1; target = reg1;   end
            3'b100: if (flag_z)      begin taken = 1'b1; target = direct; end
            3'b101: if (zero_branch) begin taken = 1'b1; target = pcimm;  end
            3'b010: go_mem = flag_n;
            3'b011: go_mem = 1'b1;
            default: ;
          endcase
        end
      end
      MEMTGT: begin
        // Memory-indirect redirects are counted here, when the target arrives.
        if (dmem_ack) begin
          advance = 1'b1;
          taken   = 1'b1;
          target  = dmem_rdata;
        end
      end
      default: ;
    endcase
  end

`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic trap;
  // Only redirects are checked; the pc4 fall-through is aligned by construction.
  assign trap    = taken && (target[1:0] != 2'b00);
  assign pc_load = trap ? TRAP_PC : target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign <= 1'b0;
    end else begin
      misalign <= trap;
    end
  end
`else
  logic unused_trap_pc;
  assign unused_trap_pc = ^TRAP_PC;
  assign pc_load        = target;
  assign misalign       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      instr     <= 32'd0;
      dmem_addr <= 32'd0;
      taken_cnt <= 16'd0;
    end else begin
      if (state_reg == FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (advance && !go_mem) begin
        pc <= pc_load;
      end
      if (go_mem) begin
        dmem_addr <= mem_addr;
      end
      if (advance && taken && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'd1;
      end
    end
  end

endmodule
